time_display_core: RTL and testbench

- Receiving end of the setting path: accepts the 17-bit total-seconds value and the three blink flags produced by the time-setting block.
- Holds a running time-of-day count and advances it once per second while running.
- Decomposes the count into six BCD digits (hh:mm:ss) through an iterative subtract-based converter.
- Digits are blanked under the blink flags and drive the 7-segment decoders downstream.

---
 rtl/time_display_core_pkg.sv | 20 ++
 rtl/time_display_core_bin2bcd_iter.sv | 34 +++
 rtl/time_display_core.sv | 154 +++++++++++++++
 tb/tb_time_display_core.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/time_display_core_pkg.sv
// Shared constants for the time-of-day path: second counts, blank code and
// converter state encoding, plus the digit blanking helper.
package time_display_core_pkg;

  localparam logic [16:0] SECS_PER_HR  = 17'd3600;
  localparam logic [16:0] SECS_PER_MIN = 17'd60;
  localparam logic [16:0] DAY_SECS     = 17'd86400;
  localparam logic [3:0]  BLANK        = 4'hF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HRS   = 3'd1;
  localparam logic [2:0] ST_MINS  = 3'd2;
  localparam logic [2:0] ST_SPLIT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [3:0] blank_digit(input logic [3:0] digit, input logic blank);
    return blank ? BLANK : digit;
  endfunction

endpackage

// File: rtl/time_display_core_bin2bcd_iter.sv
// Iterative 6-bit tens/ones splitter: start loads the value, done is high once
// the remainder is below ten (one subtraction of ten per cycle).
module bin2bcd_iter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] val;
  logic [2:0] tens_cnt;

  // Load on start, then peel off tens until the remainder is a single digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val      <= 6'd0;
      tens_cnt <= 3'd0;
    end else if (start) begin
      val      <= bin;
      tens_cnt <= 3'd0;
    end else if (val >= 6'd10) begin
      val      <= val - 6'd10;
      tens_cnt <= tens_cnt + 3'd1;
    end
  end

  assign done = (val < 6'd10);
  assign tens = {1'b0, tens_cnt};
  assign ones = val[3:0];

endmodule

// File: rtl/time_display_core.sv
// Running time-of-day counter with an iterative seconds-to-hh:mm:ss BCD
// converter and per-field blanking for the 7-segment decoders.
module time_display_core
  import time_display_core_pkg::*;
#(
  parameter logic [31:0] TICK_CYCLES = 32'd50000000,
  parameter logic [16:0] DAY_SECS    = 17'd86400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] c_in,
  input  logic        run,
  input  logic        blink_hr_sig,
  input  logic        blink_min_sig,
  input  logic        blink_sec_sig,
  output logic [3:0]  hr_tens,
  output logic [3:0]  hr_ones,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        tick_out,
  output logic        valid
);

  logic [16:0] c_in_r;
  logic [16:0] total;
  logic [31:0] tick_cnt;
  logic        tick_now;
  logic        set_pend;
  logic        pending;
  logic [2:0]  state;
  logic [16:0] w;
  logic [4:0]  h;
  logic [5:0]  m;
  logic        split_start;
  logic        h_done, m_done, s_done;
  logic [3:0]  h_t, h_o, m_t, m_o, s_t, s_o;
  logic [3:0]  hr_tens_r, hr_ones_r, min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;

  // Inputs never exceed two days, so a single subtraction brings them into range.
  assign c_in_r   = (c_in >= DAY_SECS) ? (c_in - DAY_SECS) : c_in;
  assign tick_now = run && (tick_cnt == (TICK_CYCLES - 32'd1));
  assign set_pend = run ? tick_now : (c_in_r != total);

  // Seconds timebase: tracks the setting input when stopped, counts when running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total    <= 17'd0;
      tick_cnt <= 32'd0;
      tick_out <= 1'b0;
    end else if (!run) begin
      total    <= c_in_r;
      tick_cnt <= 32'd0;
      tick_out <= 1'b0;
    end else if (tick_now) begin
      total    <= (total == (DAY_SECS - 17'd1)) ? 17'd0 : (total + 17'd1);
      tick_cnt <= 32'd0;
      tick_out <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
      tick_out <= 1'b0;
    end
  end

  // Seconds go straight from w, so the splitters load on the edge entering SPLIT.
  assign split_start = (state == ST_MINS) && (w < SECS_PER_MIN);

  // Converter FSM; digit registers change only in DONE so the display never mixes values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pending    <= 1'b1;
      w          <= 17'd0;
      h          <= 5'd0;
      m          <= 6'd0;
      hr_tens_r  <= 4'd0;
      hr_ones_r  <= 4'd0;
      min_tens_r <= 4'd0;
      min_ones_r <= 4'd0;
      sec_tens_r <= 4'd0;
      sec_ones_r <= 4'd0;
      valid      <= 1'b0;
    end else begin
      pending <= pending | set_pend;
      case (state)
        ST_IDLE: begin
          if (pending) begin
            pending <= set_pend;
            w       <= total;
            h       <= 5'd0;
            m       <= 6'd0;
            state   <= ST_HRS;
          end
        end
        ST_HRS: begin
          if (w >= SECS_PER_HR) begin
            w <= w - SECS_PER_HR;
            h <= h + 5'd1;
          end else begin
            state <= ST_MINS;
          end
        end
        ST_MINS: begin
          if (w >= SECS_PER_MIN) begin
            w <= w - SECS_PER_MIN;
            m <= m + 6'd1;
          end else begin
            state <= ST_SPLIT;
          end
        end
        ST_SPLIT: begin
          if (h_done && m_done && s_done) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          hr_tens_r  <= h_t;
          hr_ones_r  <= h_o;
          min_tens_r <= m_t;
          min_ones_r <= m_o;
          sec_tens_r <= s_t;
          sec_ones_r <= s_o;
          valid      <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bin2bcd_iter u_split_hr (
    .clk(clk), .rst(rst), .start(split_start), .bin({1'b0, h}),
    .done(h_done), .tens(h_t), .ones(h_o)
  );

  bin2bcd_iter u_split_min (
    .clk(clk), .rst(rst), .start(split_start), .bin(m),
    .done(m_done), .tens(m_t), .ones(m_o)
  );

  bin2bcd_iter u_split_sec (
    .clk(clk), .rst(rst), .start(split_start), .bin(w[5:0]),
    .done(s_done), .tens(s_t), .ones(s_o)
  );

  assign hr_tens  = blank_digit(hr_tens_r,  blink_hr_sig);
  assign hr_ones  = blank_digit(hr_ones_r,  blink_hr_sig);
  assign min_tens = blank_digit(min_tens_r, blink_min_sig);
  assign min_ones = blank_digit(min_ones_r, blink_min_sig);
  assign sec_tens = blank_digit(sec_tens_r, blink_sec_sig);
  assign sec_ones = blank_digit(sec_ones_r, blink_sec_sig);

endmodule

// File: tb/tb_time_display_core.sv
// Directed bench for time_display_core: literal digit expectations plus a
// per-cycle check that the display always shows a whole, correctly blanked time.
module tb_time_display_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] c_in = 17'd0;
  logic        run = 1'b0;
  logic        blink_hr_sig = 1'b0;
  logic        blink_min_sig = 1'b0;
  logic        blink_sec_sig = 1'b0;
  logic [3:0]  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic        tick_out;
  logic        valid;

  int tests = 0;
  int fails = 0;
  int hist[$];

  always #5 clk = ~clk;

  time_display_core #(.TICK_CYCLES(32'd4), .DAY_SECS(17'd86400)) dut (
    .clk(clk), .rst(rst), .c_in(c_in), .run(run),
    .blink_hr_sig(blink_hr_sig), .blink_min_sig(blink_min_sig), .blink_sec_sig(blink_sec_sig),
    .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .tick_out(tick_out), .valid(valid)
  );

  // Model: time of day from a seconds value using plain division.
  function automatic logic [23:0] to_digits(input int t);
    int r, hh, mm, ss;
    r  = (t >= 86400) ? t - 86400 : t;
    hh = r / 3600;
    mm = (r % 3600) / 60;
    ss = r % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [23:0] masked(input logic [23:0] d);
    logic [23:0] r;
    r = d;
    if (blink_hr_sig)  r[23:16] = 8'hFF;
    if (blink_min_sig) r[15:8]  = 8'hFF;
    if (blink_sec_sig) r[7:0]   = 8'hFF;
    return r;
  endfunction

  function automatic logic [23:0] shown();
    return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Every valid cycle must show one complete time the bench has applied.
  always @(negedge clk) begin
    if (rst && valid) begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < hist.size(); i++) begin
        if (masked(to_digits(hist[i])) == shown()) ok = 1'b1;
      end
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL digits_consistent: got %h, required a blanked time from history (latest %h) at %0t",
                 shown(), masked(to_digits(hist[hist.size()-1])), $time);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cin(input int v);
    c_in = 17'(v);
    hist.push_back((v >= 86400) ? v - 86400 : v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_digits(input string name, input logic [23:0] exp, input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (valid && shown() == exp) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL %s: got %h valid=%0b after %0d cycles, required %h", name, shown(), valid, maxc, exp);
    end
    cyc(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hist.push_back(0);
    set_cin(45296);
    cyc(2);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_digits", {8'd0, shown()}, 32'h0);
    check("reset_tick", {31'd0, tick_out}, 32'd0);
    rst = 1'b1;
    wait_digits("release_123456", 24'h123456, 100);

    set_cin(100000);
    wait_digits("reduce_100000", 24'h034640, 100);
    set_cin(131071);
    wait_digits("reduce_131071", 24'h122431, 100);
    set_cin(86400);
    wait_digits("reduce_86400", 24'h000000, 100);

    set_cin(45296);
    wait_digits("blink_base", 24'h123456, 100);
    blink_min_sig = 1'b1;
    #1;
    check("blink_min", {8'd0, shown()}, 32'h0012FF56);
    blink_min_sig = 1'b0;
    #1;
    check("blink_min_off", {8'd0, shown()}, 32'h00123456);
    blink_hr_sig = 1'b1;
    blink_sec_sig = 1'b1;
    #1;
    check("blink_hr_sec", {8'd0, shown()}, 32'h00FF34FF);
    cyc(3);
    blink_hr_sig = 1'b0;
    blink_sec_sig = 1'b0;

    set_cin(86399);
    wait_digits("load_235959", 24'h235959, 100);
    for (int k = 0; k < 6; k++) hist.push_back(k);
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      check("tick_early", {31'd0, tick_out}, 32'd0);
    end
    cyc(1);
    check("tick_pulse", {31'd0, tick_out}, 32'd1);
    cyc(1);
    check("tick_one_cycle", {31'd0, tick_out}, 32'd0);
    wait_digits("wrap_000000", 24'h000000, 12);
    wait_digits("next_000001", 24'h000001, 12);
    run = 1'b0;
    cyc(1);
    check("stopped_tick", {31'd0, tick_out}, 32'd0);
    wait_digits("reload_235959", 24'h235959, 100);

    set_cin(0);
    wait_digits("busy_base", 24'h000000, 100);
    set_cin(3599);
    cyc(3);
    set_cin(3600);
    wait_digits("busy_first_005959", 24'h005959, 100);
    wait_digits("busy_second_010000", 24'h010000, 100);

    set_cin(86399);
    cyc(10);
    rst = 1'b0;
    #1;
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_digits", {8'd0, shown()}, 32'h0);
    cyc(2);
    rst = 1'b1;
    wait_digits("after_reset_235959", 24'h235959, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
